// File: rtl/alu_md_if.sv
// Request/response bundle between a requester and the alu_md execution unit.
// The requester drives the operation and out_ready; alu_md answers with in_ready, the result and busy.
interface alu_md_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [2:0]      func3;
  logic [6:0]      func7;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_out;
  logic            busy;

  modport master (
    output in_valid, opcode, func3, func7, operand1, operand2, out_ready,
    input  in_ready, out_valid, alu_out, busy
  );

  modport slave (
    input  in_valid, opcode, func3, func7, operand1, operand2, out_ready,
    output in_ready, out_valid, alu_out, busy
  );
endinterface

// File: rtl/alu_md.sv
// RV32/RV64 integer ALU with M extension: single-cycle ops and multiply, plus a
// one-bit-per-cycle restoring divider; results wait in HOLD until the consumer takes them.
module alu_md #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input logic     clk,
  input logic     rst,
  alu_md_if.slave bus
);
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [6:0] F7_MUL   = 7'b0000001;
  localparam int         CW       = $clog2(XLEN);
  // On RV64 the immediate shifts carry shamt[5] in func7[0], so it is not part of the func7 check.
  localparam logic [6:0] SHAMT_MASK = (XLEN == 64) ? 7'b1111110 : 7'b1111111;

  typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic              w_inReady;
  logic              w_outValid;
  logic              w_busy;
  logic              w_accept;
  logic              w_divStart;
  logic [XLEN-1:0]   w_result;

  logic [XLEN-1:0]   w_op1;
  logic [XLEN-1:0]   w_op2;
  logic [SHW-1:0]    w_shamt;
  logic [6:0]        w_f7Shift;
  logic              w_eq;
  logic              w_lt;
  logic              w_ltu;
  logic [XLEN-1:0]   w_sll;
  logic [XLEN-1:0]   w_srl;
  logic [XLEN-1:0]   w_sra;

  logic              w_mSignA;
  logic              w_mSignB;
  logic [2*XLEN-1:0] w_mA;
  logic [2*XLEN-1:0] w_mB;
  logic [2*XLEN-1:0] w_prod;

  logic              w_divSigned;
  logic              w_isRemOp;
  logic              w_divZero;
  logic              w_divOvf;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;

  logic [XLEN-1:0]   r_aluOut;
  logic [XLEN-1:0]   r_dividend;
  logic [XLEN-1:0]   r_divisor;
  logic [XLEN-1:0]   r_rem;
  logic [CW-1:0]     r_cnt;
  logic              r_negQ;
  logic              r_negR;
  logic              r_isRem;
  logic [XLEN:0]     w_remShift;
  logic [XLEN:0]     w_diff;
  logic              w_qBit;
  logic [XLEN-1:0]   w_qNext;
  logic [XLEN-1:0]   w_rNext;
  logic [XLEN-1:0]   w_qFinal;
  logic [XLEN-1:0]   w_rFinal;
  logic              w_lastIter;

  assign w_op1     = bus.operand1;
  assign w_op2     = bus.operand2;
  assign w_shamt   = bus.operand2[SHW-1:0];
  assign w_f7Shift = bus.func7 & SHAMT_MASK;
  assign w_eq      = (w_op1 == w_op2);
  assign w_lt      = ($signed(w_op1) < $signed(w_op2));
  assign w_ltu     = (w_op1 < w_op2);
  assign w_sll     = w_op1 << w_shamt;
  assign w_srl     = w_op1 >> w_shamt;
  assign w_sra     = XLEN'($signed(w_op1) >>> w_shamt);

  // A single 2*XLEN multiplier serves all four multiplies by choosing how each operand is extended.
  assign w_mSignA = (bus.func3 == 3'b001) || (bus.func3 == 3'b010);
  assign w_mSignB = (bus.func3 == 3'b001);
  assign w_mA     = {{XLEN{w_mSignA & w_op1[XLEN-1]}}, w_op1};
  assign w_mB     = {{XLEN{w_mSignB & w_op2[XLEN-1]}}, w_op2};
  assign w_prod   = w_mA * w_mB;

  assign w_divSigned = ~bus.func3[0];
  assign w_isRemOp   = bus.func3[1];
  assign w_divZero   = (w_op2 == '0);
  assign w_divOvf    = w_divSigned && (w_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (w_op2 == '1);
  assign w_mag1      = (w_divSigned && w_op1[XLEN-1]) ? -w_op1 : w_op1;
  assign w_mag2      = (w_divSigned && w_op2[XLEN-1]) ? -w_op2 : w_op2;

  always_comb begin
    w_result   = '0;
    w_divStart = 1'b0;
    case (bus.opcode)
      OP_I: begin
        case (bus.func3)
          3'b000: w_result = w_op1 + w_op2;
          3'b001: if (w_f7Shift == F7_BASE) w_result = w_sll;
          3'b010: w_result = XLEN'(w_lt);
          3'b011: w_result = XLEN'(w_ltu);
          3'b100: w_result = w_op1 ^ w_op2;
          3'b101: begin
            if (w_f7Shift == F7_BASE)     w_result = w_srl;
            else if (w_f7Shift == F7_ALT) w_result = w_sra;
          end
          3'b110: w_result = w_op1 | w_op2;
          3'b111: w_result = w_op1 & w_op2;
          default: ;
        endcase
      end
      OP_R: begin
        if (bus.func7 == F7_BASE) begin
          case (bus.func3)
            3'b000: w_result = w_op1 + w_op2;
            3'b001: w_result = w_sll;
            3'b010: w_result = XLEN'(w_lt);
            3'b011: w_result = XLEN'(w_ltu);
            3'b100: w_result = w_op1 ^ w_op2;
            3'b101: w_result = w_srl;
            3'b110: w_result = w_op1 | w_op2;
            3'b111: w_result = w_op1 & w_op2;
            default: ;
          endcase
        end else if (bus.func7 == F7_ALT) begin
          case (bus.func3)
            3'b000: w_result = w_op1 - w_op2;
            3'b101: w_result = w_sra;
            default: ;
          endcase
        end else if (bus.func7 == F7_MUL) begin
          case (bus.func3)
            3'b000:                 w_result = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_result = w_prod[2*XLEN-1:XLEN];
            default: begin
              // Zero divisor and signed overflow resolve immediately; everything else iterates.
              if (w_divZero)     w_result = w_isRemOp ? w_op1 : '1;
              else if (w_divOvf) w_result = w_isRemOp ? '0 : w_op1;
              else               w_divStart = 1'b1;
            end
          endcase
        end
      end
      OP_B: begin
        case (bus.func3)
          3'b000: w_result = XLEN'(w_eq);
          3'b001: w_result = XLEN'(!w_eq);
          3'b100: w_result = XLEN'(w_lt);
          3'b101: w_result = XLEN'(!w_lt);
          3'b110: w_result = XLEN'(w_ltu);
          3'b111: w_result = XLEN'(!w_ltu);
          default: ;
        endcase
      end
      OP_L: begin
        case (bus.func3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_result = w_op1 + w_op2;
          3'b011, 3'b110: if (XLEN == 64) w_result = w_op1 + w_op2;
          default: ;
        endcase
      end
      OP_S: begin
        case (bus.func3)
          3'b000, 3'b001, 3'b010: w_result = w_op1 + w_op2;
          3'b011: if (XLEN == 64) w_result = w_op1 + w_op2;
          default: ;
        endcase
      end
      OP_LUI:   w_result = {w_op2[XLEN-1:12], 12'b0};
      OP_AUIPC: w_result = w_op1 + {w_op2[XLEN-1:12], 12'b0};
      OP_JAL:   w_result = w_op1 + XLEN'(4);
      OP_JALR:  if (bus.func3 == 3'b000) w_result = w_op1 + XLEN'(4);
      default: ;
    endcase
  end

  // One restoring step: shift in the next dividend bit and keep the difference if it did not borrow.
  assign w_remShift = {r_rem, r_dividend[XLEN-1]};
  assign w_diff     = w_remShift - {1'b0, r_divisor};
  assign w_qBit     = ~w_diff[XLEN];
  assign w_rNext    = w_qBit ? w_diff[XLEN-1:0] : w_remShift[XLEN-1:0];
  assign w_qNext    = {r_dividend[XLEN-2:0], w_qBit};
  assign w_qFinal   = r_negQ ? -w_qNext : w_qNext;
  assign w_rFinal   = r_negR ? -w_rNext : w_rNext;
  assign w_lastIter = (r_cnt == CW'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_accept) w_nextState = w_divStart ? DIV : HOLD;
      DIV:  if (w_lastIter) w_nextState = HOLD;
      HOLD: begin
        if (w_accept)           w_nextState = w_divStart ? DIV : HOLD;
        else if (bus.out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_inReady  = 1'b0;
    w_outValid = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      IDLE: w_inReady = 1'b1;
      DIV:  w_busy = 1'b1;
      HOLD: begin
        w_inReady  = bus.out_ready;
        w_outValid = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_accept      = bus.in_valid && w_inReady;
  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.busy      = w_busy;
  assign bus.alu_out   = r_aluOut;

  // alu_out moves only when a single-cycle op is accepted or the divider finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aluOut   <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_negQ     <= 1'b0;
      r_negR     <= 1'b0;
      r_isRem    <= 1'b0;
    end else if (w_accept && w_divStart) begin
      r_dividend <= w_mag1;
      r_divisor  <= w_mag2;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_negQ     <= w_divSigned && (w_op1[XLEN-1] ^ w_op2[XLEN-1]);
      r_negR     <= w_divSigned && w_op1[XLEN-1];
      r_isRem    <= w_isRemOp;
    end else if (w_accept) begin
      r_aluOut <= w_result;
    end else if (r_state == DIV) begin
      r_dividend <= w_qNext;
      r_rem      <= w_rNext;
      r_cnt      <= r_cnt + CW'(1);
      if (w_lastIter) r_aluOut <= r_isRem ? w_rFinal : w_qFinal;
    end
  end
endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md: a 32-bit instance for the bulk of the ops and
// handshake cases, and a 64-bit instance for the long-division latency.
module tb_alu_md;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [6:0] F7_MUL   = 7'b0000001;

  logic clk = 1'b0;
  logic rst;
  int   nAsserts = 0;
  int   nFails   = 0;

  alu_md_if #(.XLEN(32)) bus32 ();
  alu_md_if #(.XLEN(64)) bus64 ();

  alu_md #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  alu_md #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] a, input logic [31:0] b);
    bus32.in_valid = 1'b1;
    bus32.opcode   = opc;
    bus32.func3    = f3;
    bus32.func7    = f7;
    bus32.operand1 = a;
    bus32.operand2 = b;
  endtask

  // Back-to-back single-cycle op: result must be on alu_out one edge after acceptance.
  task automatic runVec(input string tag, input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] expected);
    applyStimulus(opc, f3, f7, a, b);
    @(negedge clk);
    checkOutput({tag, " out_valid"}, 64'(bus32.out_valid), 64'd1);
    checkOutput({tag, " alu_out"}, 64'(bus32.alu_out), 64'(expected));
    checkOutput({tag, " in_ready"}, 64'(bus32.in_ready), 64'd1);
  endtask

  task automatic divCase(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expected);
    int cyc;
    int busyCnt;
    applyStimulus(OP_R, f3, F7_MUL, a, b);
    @(negedge clk);
    checkOutput({tag, " in_ready in DIV"}, 64'(bus32.in_ready), 64'd0);
    applyStimulus(OP_R, 3'b000, F7_BASE, 32'd1, 32'd1);
    cyc = 1;
    busyCnt = 0;
    while (!bus32.out_valid && cyc < 200) begin
      if (bus32.busy) busyCnt++;
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, " out_valid"}, 64'(bus32.out_valid), 64'd1);
    checkOutput({tag, " latency"}, 64'(cyc), 64'd33);
    checkOutput({tag, " busy cycles"}, 64'(busyCnt), 64'd32);
    checkOutput({tag, " alu_out"}, 64'(bus32.alu_out), 64'(expected));
    bus32.in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int busyCnt;
    int validCnt;

    rst = 1'b1;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
    bus32.opcode = '0; bus32.func3 = '0; bus32.func7 = '0; bus32.operand1 = '0; bus32.operand2 = '0;
    bus64.in_valid = 1'b0; bus64.out_ready = 1'b1;
    bus64.opcode = '0; bus64.func3 = '0; bus64.func7 = '0; bus64.operand1 = '0; bus64.operand2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");
    checkOutput("reset out_valid", 64'(bus32.out_valid), 64'd0);
    checkOutput("reset busy", 64'(bus32.busy), 64'd0);
    checkOutput("reset alu_out", 64'(bus32.alu_out), 64'd0);
    checkOutput("reset in_ready", 64'(bus32.in_ready), 64'd1);
    checkOutput("reset alu_out64", bus64.alu_out, 64'd0);

    runVec("ADD",    OP_R, 3'b000, F7_BASE, 32'd5,         32'd7,         32'd12);
    runVec("SUB",    OP_R, 3'b000, F7_ALT,  32'd5,         32'd7,         32'hFFFFFFFE);
    runVec("SLL",    OP_R, 3'b001, F7_BASE, 32'd1,         32'h0000003F,  32'h80000000);
    runVec("SLT",    OP_R, 3'b010, F7_BASE, 32'hFFFFFFFF,  32'd1,         32'd1);
    runVec("SLTU",   OP_R, 3'b011, F7_BASE, 32'hFFFFFFFF,  32'd1,         32'd0);
    runVec("XOR",    OP_R, 3'b100, F7_BASE, 32'h0000F0F0,  32'h00000FF0,  32'h0000FF00);
    runVec("SRL",    OP_R, 3'b101, F7_BASE, 32'h80000000,  32'd4,         32'h08000000);
    runVec("SRA",    OP_R, 3'b101, F7_ALT,  32'h80000000,  32'd4,         32'hF8000000);
    runVec("OR",     OP_R, 3'b110, F7_BASE, 32'h0000F000,  32'h0000000F,  32'h0000F00F);
    runVec("AND",    OP_R, 3'b111, F7_BASE, 32'h0000FF00,  32'h00000FF0,  32'h00000F00);
    runVec("ADDI",   OP_I, 3'b000, F7_BASE, 32'd100,       32'hFFFFFFFF,  32'd99);
    runVec("SRAI",   OP_I, 3'b101, F7_ALT,  32'hFFFF0000,  32'd8,         32'hFFFFFF00);
    runVec("BEQ",    OP_B, 3'b000, F7_BASE, 32'd3,         32'd3,         32'd1);
    runVec("BNE",    OP_B, 3'b001, F7_BASE, 32'd3,         32'd3,         32'd0);
    runVec("BLT",    OP_B, 3'b100, F7_BASE, 32'hFFFFFFFB,  32'd2,         32'd1);
    runVec("BGE",    OP_B, 3'b101, F7_BASE, 32'hFFFFFFFB,  32'd2,         32'd0);
    runVec("BLTU",   OP_B, 3'b110, F7_BASE, 32'hFFFFFFFB,  32'd2,         32'd0);
    runVec("BGEU",   OP_B, 3'b111, F7_BASE, 32'hFFFFFFFB,  32'd2,         32'd1);
    runVec("LW",     OP_L, 3'b010, F7_BASE, 32'h00001000,  32'h00000010,  32'h00001010);
    runVec("SW",     OP_S, 3'b010, F7_BASE, 32'h00002000,  32'hFFFFFFFC,  32'h00001FFC);
    runVec("LUI",    OP_LUI,   3'b000, F7_BASE, 32'd0,     32'h12345ABC,  32'h12345000);
    runVec("AUIPC",  OP_AUIPC, 3'b000, F7_BASE, 32'h100,   32'h00001FFF,  32'h00001100);
    runVec("JAL",    OP_JAL,   3'b000, F7_BASE, 32'h200,   32'd0,         32'h00000204);
    runVec("JALR",   OP_JALR,  3'b000, F7_BASE, 32'h300,   32'd8,         32'h00000304);
    runVec("MUL",    OP_R, 3'b000, F7_MUL,  32'hFFFFFFFF,  32'd3,         32'hFFFFFFFD);
    runVec("MULH",   OP_R, 3'b001, F7_MUL,  32'h80000000,  32'h80000000,  32'h40000000);
    runVec("MULHSU", OP_R, 3'b010, F7_MUL,  32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF);
    runVec("MULHU",  OP_R, 3'b011, F7_MUL,  32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE);
    runVec("bad opcode", 7'b1111111, 3'b000, F7_BASE, 32'd5, 32'd7,       32'd0);
    runVec("bad func7",  OP_R, 3'b001, F7_ALT,  32'd5,     32'd7,         32'd0);
    runVec("bad branch", OP_B, 3'b010, F7_BASE, 32'd5,     32'd5,         32'd0);
    runVec("DIVU /0",  OP_R, 3'b101, F7_MUL, 32'd10,       32'd0,         32'hFFFFFFFF);
    runVec("REMU /0",  OP_R, 3'b111, F7_MUL, 32'd10,       32'd0,         32'd10);
    runVec("DIV ovf",  OP_R, 3'b100, F7_MUL, 32'h80000000, 32'hFFFFFFFF,  32'h80000000);
    runVec("REM ovf",  OP_R, 3'b110, F7_MUL, 32'h80000000, 32'hFFFFFFFF,  32'd0);
    runVec("DIV /0",   OP_R, 3'b100, F7_MUL, 32'hFFFFFFF9, 32'd0,         32'hFFFFFFFF);
    runVec("REM /0",   OP_R, 3'b110, F7_MUL, 32'hFFFFFFF9, 32'd0,         32'hFFFFFFF9);

    bus32.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("drain out_valid", 64'(bus32.out_valid), 64'd0);
    checkOutput("drain alu_out kept", 64'(bus32.alu_out), 64'hFFFFFFF9);

    divCase("DIV -7/2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    divCase("REM -7/2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    divCase("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14);

    // Consumer stalls while an SRA result waits; a queued ADD must not be taken until release.
    bus32.out_ready = 1'b0;
    applyStimulus(OP_R, 3'b101, F7_ALT, 32'h80000000, 32'd4);
    @(negedge clk);
    checkOutput("stall out_valid", 64'(bus32.out_valid), 64'd1);
    checkOutput("stall alu_out", 64'(bus32.alu_out), 64'hF8000000);
    applyStimulus(OP_R, 3'b000, F7_BASE, 32'd1, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("stall held alu_out", 64'(bus32.alu_out), 64'hF8000000);
      checkOutput("stall in_ready", 64'(bus32.in_ready), 64'd0);
      checkOutput("stall held out_valid", 64'(bus32.out_valid), 64'd1);
    end
    bus32.out_ready = 1'b1;
    #1;
    checkOutput("release in_ready", 64'(bus32.in_ready), 64'd1);
    @(negedge clk);
    checkOutput("overlap out_valid", 64'(bus32.out_valid), 64'd1);
    checkOutput("overlap alu_out", 64'(bus32.alu_out), 64'd2);
    bus32.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("overlap drained", 64'(bus32.out_valid), 64'd0);

    // Reset ten cycles into a division must drop it without ever presenting a result.
    applyStimulus(OP_R, 3'b100, F7_MUL, 32'd100, 32'd7);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("abort busy before rst", 64'(bus32.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort out_valid", 64'(bus32.out_valid), 64'd0);
    checkOutput("abort busy", 64'(bus32.busy), 64'd0);
    checkOutput("abort alu_out", 64'(bus32.alu_out), 64'd0);
    checkOutput("abort in_ready", 64'(bus32.in_ready), 64'd1);
    validCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus32.out_valid) validCnt++;
    end
    checkOutput("abort no result", 64'(validCnt), 64'd0);

    bus64.opcode   = OP_R;
    bus64.func3    = 3'b100;
    bus64.func7    = F7_MUL;
    bus64.operand1 = 64'hFFFFFFFFFFFFFFF9;
    bus64.operand2 = 64'd2;
    bus64.in_valid = 1'b1;
    @(negedge clk);
    bus64.in_valid = 1'b0;
    cyc = 1;
    busyCnt = 0;
    while (!bus64.out_valid && cyc < 300) begin
      if (bus64.busy) busyCnt++;
      @(negedge clk);
      cyc++;
    end
    checkOutput("DIV64 out_valid", 64'(bus64.out_valid), 64'd1);
    checkOutput("DIV64 latency", 64'(cyc), 64'd65);
    checkOutput("DIV64 busy cycles", 64'(busyCnt), 64'd64);
    checkOutput("DIV64 alu_out", bus64.alu_out, 64'hFFFFFFFFFFFFFFFD);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
